fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register feeding the control unit.
//  Owns the PC, issues icache reads, latches the returned word plus PC+4 into IF/ID.
//  Applies decode-stage redirects (branch/jump/jr) and hazard-unit stall/flush.
//  Parks in a terminal state once a HALT opcode (6'b111111) enters IF/ID.
// PARAMETERS
//  PC_RESET    32'h0000_0000  PC value loaded on reset
//  HALT_OP     6'b111111      opcode treated as halt
// PORTS
//  CLK            in   1   clock, all state updates on rising edge
//  nRST           in   1   reset; synchronous, active-low
//  ihit           in   1   icache returns valid word this cycle
//  iload          in   32  instruction word from icache
//  imemREN        out  1   icache read request
//  imemaddr       out  32  icache address (= current PC)
//  stall          in   1   hazard unit: hold PC and IF/ID
//  flush          in   1   hazard unit: squash IF/ID contents
//  pc_src         in   2   0 seq, 1 branch taken, 2 jump/jal/jr, 3 reserved(=0)
//  branch_addr    in   32  taken-branch target from decode
//  jump_addr      in   32  j/jal/jr target from decode
//  ifid_instr     out  32  instruction to control unit
//  ifid_npc       out  32  PC+4 of that instruction
//  ifid_valid     out  1   IF/ID holds a real instruction
//  halted         out  1   fetch stopped on HALT
// BEHAVIOUR
//  Reset (nRST=0 at edge): pc=PC_RESET, ifid_instr=0, ifid_npc=0, ifid_valid=0,
//   halted=0, state=FETCH. imemREN=0 combinationally while nRST=0.
//  States: FETCH, WAIT_STALL, HALTED.
//  FETCH: imemREN=1, imemaddr=pc. On ihit & !stall: IF/ID<={iload,pc+4,1},
//   pc<=next_pc. On ihit & stall: word held internally, ->WAIT_STALL, imemREN=0.
//   No ihit: IF/ID unchanged unless flush; pc unchanged.
//  WAIT_STALL: imemREN=0; when stall drops, held word enters IF/ID, pc<=next_pc, ->FETCH.
//  next_pc: pc_src=1 branch_addr; 2 jump_addr; else pc+4 (wraps mod 2^32).
//  Redirect (pc_src!=0) is honoured the cycle it is presented, even without ihit:
//   pc<=target, any in-flight/held fetch dropped, ->FETCH.
//  flush: ifid_valid<=0, ifid_instr<=0 (sll $0 NOP); wins over a same-cycle load.
//  stall & flush same cycle: flush applies to IF/ID, pc holds.
//  HALT: when word loaded into IF/ID has [31:26]==HALT_OP -> HALTED next cycle:
//   imemREN=0, pc frozen, halted=1, IF/ID frozen; only reset leaves HALTED.
//   A flush of that HALT before the transition cancels it (state stays FETCH).
//  Latency: ihit at edge N -> ifid_instr valid after edge N (1 cycle, no bubble).
//  imemaddr low 2 bits always driven from pc; misaligned targets not checked.
// CONFIGURATION
//  FETCH_SKID_EN defined: 1-entry skid buffer; in FETCH with stall, fetching
//   continues and the first ihit fills the skid (imemREN drops only once full);
//   on stall release skid -> IF/ID with zero bubble. Redirect/flush empties skid.
//  FETCH_SKID_EN undefined: behaviour exactly as above (WAIT_STALL path only).
// TESTING
//  Reset: nRST=0 2 cycles -> imemaddr=0, ifid_valid=0, halted=0, imemREN=0.
//  Seq: ihit=1 every cycle, iload=0x3421_0001 -> imemaddr 0,4,8; ifid_npc 4,8,12.
//  Branch: pc=0x10, pc_src=1, branch_addr=0x40 -> next imemaddr=0x40, held word dropped.
//  Stall: stall=1 3 cycles w/ ihit -> pc, IF/ID constant; release -> IF/ID loads held word.
//  Flush+stall same cycle -> ifid_valid=0, ifid_instr=0, pc unchanged.
//  Halt: iload=0xFFFF_FFFF at pc=0x8 -> halted=1 next cycle, imemREN=0, pc=0x8 to reset.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: icache request/response, hazard and redirect inputs, and the IF/ID register outputs.
interface fetch_if;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  modport master (
    input  ihit, iload, stall, flush, pc_src, branch_addr, jump_addr,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, halted
  );
  modport slave (
    output ihit, iload, stall, flush, pc_src, branch_addr, jump_addr,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, redirect, stall/flush and HALT parking.
// FETCH_SKID_EN: keep fetching while stalled until a 1-entry skid holds a word.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic     CLK,
  input  logic     nRST,
  fetch_if.master  bus
);
  typedef enum logic [1:0] {FETCH, WAIT_STALL, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] held_instr;
  logic        held_vld;
  logic        redirect;
  logic        halt_pend;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign redirect  = (bus.pc_src == 2'd1) || (bus.pc_src == 2'd2);
  assign next_pc   = (bus.pc_src == 2'd1) ? bus.branch_addr :
                     (bus.pc_src == 2'd2) ? bus.jump_addr   : pc_plus4;
  // A HALT sitting in IF/ID freezes fetch for one cycle so a flush can still cancel it.
  assign halt_pend = (state != HALTED) && bus.ifid_valid &&
                     (bus.ifid_instr[31:26] == HALT_OP);

  assign bus.imemaddr = pc;
  assign bus.imemREN  = nRST && (state == FETCH) && !held_vld && !halt_pend;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state          <= FETCH;
      pc             <= PC_RESET;
      held_instr     <= '0;
      held_vld       <= 1'b0;
      bus.ifid_instr <= '0;
      bus.ifid_npc   <= '0;
      bus.ifid_valid <= 1'b0;
      bus.halted     <= 1'b0;
    end else begin
      case (state)
        FETCH, WAIT_STALL: begin
          if (bus.flush) begin
            // Squash IF/ID and any held word; pc stays put so the word is refetched.
            bus.ifid_valid <= 1'b0;
            bus.ifid_instr <= '0;
            held_vld       <= 1'b0;
            state          <= FETCH;
            if (redirect) pc <= next_pc;
          end else if (halt_pend) begin
            state      <= HALTED;
            bus.halted <= 1'b1;
          end else if (redirect) begin
            pc       <= next_pc;
            held_vld <= 1'b0;
            state    <= FETCH;
          end else if (held_vld) begin
            if (!bus.stall) begin
              bus.ifid_instr <= held_instr;
              bus.ifid_npc   <= pc_plus4;
              bus.ifid_valid <= 1'b1;
              held_vld       <= 1'b0;
              state          <= FETCH;
              if (held_instr[31:26] != HALT_OP) pc <= pc_plus4;
            end
          end else if ((state == FETCH) && bus.ihit) begin
            if (bus.stall) begin
              held_instr <= bus.iload;
              held_vld   <= 1'b1;
`ifdef FETCH_SKID_EN
              state      <= FETCH;
`else
              state      <= WAIT_STALL;
`endif
            end else begin
              bus.ifid_instr <= bus.iload;
              bus.ifid_npc   <= pc_plus4;
              bus.ifid_valid <= 1'b1;
              if (bus.iload[31:26] != HALT_OP) pc <= pc_plus4;
            end
          end
        end
        default: state <= HALTED;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, branch, stall, flush, jump wrap, halt.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic nrst;
  int   pass_n = 0;
  int   total_n = 0;

  fetch_if bus();

  fetch_stage dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    nrst = 1'b0;
    bus.ihit = 1'b0; bus.iload = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.pc_src = 2'd0; bus.branch_addr = '0; bus.jump_addr = '0;
    tick(); tick();
    chk("rst_addr",   bus.imemaddr, 32'h0);
    chk("rst_valid",  {31'b0, bus.ifid_valid}, 32'd0);
    chk("rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("rst_ren",    {31'b0, bus.imemREN}, 32'd0);
    nrst = 1'b1; #1;
    chk("ren_after_rst", {31'b0, bus.imemREN}, 32'd1);

    // sequential fetch
    bus.ihit = 1'b1; bus.iload = 32'h3421_0001;
    chk("seq_addr0", bus.imemaddr, 32'h0);
    tick();
    chk("seq_npc4",  bus.ifid_npc, 32'h4);
    chk("seq_addr4", bus.imemaddr, 32'h4);
    chk("seq_instr", bus.ifid_instr, 32'h3421_0001);
    chk("seq_valid", {31'b0, bus.ifid_valid}, 32'd1);
    tick();
    chk("seq_npc8",  bus.ifid_npc, 32'h8);
    chk("seq_addr8", bus.imemaddr, 32'h8);
    tick();
    chk("seq_npc12", bus.ifid_npc, 32'hC);
    tick();
    chk("seq_addr16", bus.imemaddr, 32'h10);

    // branch drops a held word
    bus.stall = 1'b1; bus.iload = 32'hAAAA_0000;
    tick();
    chk("hold_ren",  {31'b0, bus.imemREN}, 32'd0);
    chk("hold_addr", bus.imemaddr, 32'h10);
    bus.stall = 1'b0; bus.ihit = 1'b0; bus.pc_src = 2'd1; bus.branch_addr = 32'h40;
    tick();
    bus.pc_src = 2'd0;
    chk("br_addr",  bus.imemaddr, 32'h40);
    chk("br_ren",   {31'b0, bus.imemREN}, 32'd1);
    chk("br_instr", bus.ifid_instr, 32'h3421_0001);
    chk("br_npc",   bus.ifid_npc, 32'h10);

    // stall three cycles with ihit, then release
    bus.stall = 1'b1; bus.ihit = 1'b1; bus.iload = 32'h2000_0005;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr",  bus.imemaddr, 32'h40);
      chk("stall_npc",   bus.ifid_npc, 32'h10);
      chk("stall_instr", bus.ifid_instr, 32'h3421_0001);
    end
    bus.stall = 1'b0; bus.ihit = 1'b0;
    tick();
    chk("rel_instr", bus.ifid_instr, 32'h2000_0005);
    chk("rel_npc",   bus.ifid_npc, 32'h44);
    chk("rel_addr",  bus.imemaddr, 32'h44);

    // flush and stall together
    bus.stall = 1'b1; bus.flush = 1'b1; bus.ihit = 1'b1; bus.iload = 32'h1111_1111;
    tick();
    chk("fs_valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("fs_instr", bus.ifid_instr, 32'h0);
    chk("fs_addr",  bus.imemaddr, 32'h44);
    bus.stall = 1'b0; bus.flush = 1'b0; bus.ihit = 1'b0;

    // jump to top of address space, then sequential wrap with reserved pc_src
    bus.pc_src = 2'd2; bus.jump_addr = 32'hFFFF_FFFC;
    tick();
    chk("jmp_addr", bus.imemaddr, 32'hFFFF_FFFC);
    bus.pc_src = 2'd3; bus.branch_addr = 32'h999; bus.ihit = 1'b1; bus.iload = 32'h1234_5678;
    tick();
    chk("wrap_addr",  bus.imemaddr, 32'h0);
    chk("wrap_npc",   bus.ifid_npc, 32'h0);
    chk("wrap_instr", bus.ifid_instr, 32'h1234_5678);
    bus.pc_src = 2'd0; bus.ihit = 1'b0;

    // halt cancelled by flush
    nrst = 1'b0; tick(); tick(); nrst = 1'b1;
    bus.ihit = 1'b1; bus.iload = 32'hFFFF_FFFF;
    tick();
    chk("hp_addr", bus.imemaddr, 32'h0);
    chk("hp_ren",  {31'b0, bus.imemREN}, 32'd0);
    bus.ihit = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("hc_halted", {31'b0, bus.halted}, 32'd0);
    chk("hc_ren",    {31'b0, bus.imemREN}, 32'd1);
    tick();
    chk("hc_halted2", {31'b0, bus.halted}, 32'd0);

    // halt at pc 0x8
    bus.ihit = 1'b1; bus.iload = 32'h3421_0001;
    tick(); tick();
    chk("h_addr8", bus.imemaddr, 32'h8);
    bus.iload = 32'hFFFF_FFFF;
    tick();
    chk("h_instr", bus.ifid_instr, 32'hFFFF_FFFF);
    chk("h_pend_halted", {31'b0, bus.halted}, 32'd0);
    tick();
    chk("h_halted", {31'b0, bus.halted}, 32'd1);
    chk("h_ren",    {31'b0, bus.imemREN}, 32'd0);
    chk("h_addr",   bus.imemaddr, 32'h8);
    bus.pc_src = 2'd1; bus.branch_addr = 32'h40; bus.iload = 32'h3421_0001;
    tick(); tick();
    chk("h_frozen_addr",  bus.imemaddr, 32'h8);
    chk("h_frozen_halt",  {31'b0, bus.halted}, 32'd1);
    chk("h_frozen_instr", bus.ifid_instr, 32'hFFFF_FFFF);
    bus.pc_src = 2'd0; bus.ihit = 1'b0;
    nrst = 1'b0; tick();
    chk("h_rst_halted", {31'b0, bus.halted}, 32'd0);
    chk("h_rst_addr",   bus.imemaddr, 32'h0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
